// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Multi-channel push-button conditioner. Each channel has a
//               2-flop synchronizer, an active-low to active-high inversion
//               and a stable-count debouncer. It produces a debounced level
//               and registered one-cycle press/release pulses.
//               Optional auto-repeat of press pulses while a button is held
//               is enabled by defining the macro BUTTON_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
   parameter int NUM_BUTTONS     = 3,
   parameter int DEBOUNCE_CYCLES = 120_000,
   parameter int REPEAT_DELAY    = 6_000_000,
   parameter int REPEAT_PERIOD   = 1_200_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] button_i,
   output logic [NUM_BUTTONS-1:0] pressed_o,
   output logic [NUM_BUTTONS-1:0] press_o,
   output logic [NUM_BUTTONS-1:0] release_o
);

   localparam int               c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int               c_REP_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                                 REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               c_REP_W        = $clog2(c_REP_MAX + 1);
   localparam logic [c_REP_W-1:0] c_REP_DLY_LAST = c_REP_W'(REPEAT_DELAY - 1);
   localparam logic [c_REP_W-1:0] c_REP_PER_LAST = c_REP_W'(REPEAT_PERIOD - 1);
`endif

   // Elaboration-time sanity hook; also keeps the repeat parameters referenced
   // when the auto-repeat feature is compiled out.
   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_illegal_params
   end

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
      logic               sync_meta_q;
      logic               sync_n_q;
      logic [c_CNT_W-1:0] cnt_q,     cnt_d;
      logic               pressed_q, pressed_d;
      logic               press_q,   press_d;
      logic               release_q, release_d;
      logic               w_differs;
      logic               w_toggle;
      logic               w_repeat;

      // Two-flop synchronizer; the pad is inverted on entry so 0 means released
      always_ff @(posedge clk) begin
         if (reset) begin
            sync_meta_q <= 1'b0;
            sync_n_q    <= 1'b0;
         end else begin
            sync_meta_q <= ~button_i[g];
            sync_n_q    <= sync_meta_q;
         end
      end

      assign w_differs = sync_n_q ^ pressed_q;
      // The cycle the count would reach DEBOUNCE_CYCLES is the toggle cycle
      assign w_toggle  = w_differs && (cnt_q == c_CNT_LAST);

`ifdef BUTTON_AUTOREPEAT_EN
      logic [c_REP_W-1:0] rep_cnt_q,   rep_cnt_d;
      logic               rep_first_q, rep_first_d;

      // Repeat timer: initial delay after the press, then a fixed period
      always_comb begin
         rep_cnt_d   = rep_cnt_q;
         rep_first_d = rep_first_q;
         w_repeat    = 1'b0;
         if (!pressed_q || w_toggle) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
         end else if (rep_cnt_q == (rep_first_q ? c_REP_DLY_LAST : c_REP_PER_LAST)) begin
            w_repeat    = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
         end else begin
            rep_cnt_d   = rep_cnt_q + c_REP_W'(1);
         end
      end

      // Repeat timer state
      always_ff @(posedge clk) begin
         if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
         end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
         end
      end
`else
      assign w_repeat = 1'b0;
`endif

      // Debounce counter, debounced level and edge pulses next-state
      always_comb begin
         cnt_d = cnt_q;
         if (!w_differs || w_toggle) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
         end
         pressed_d = pressed_q ^ w_toggle;
         press_d   = (w_toggle & ~pressed_q) | w_repeat;
         release_d = w_toggle & pressed_q;
      end

      // Debounce state and registered outputs
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      assign pressed_o[g] = pressed_q;
      assign press_o[g]   = press_q;
      assign release_o[g] = release_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4,
//               REPEAT_DELAY=10, REPEAT_PERIOD=3). Stimulus pushes expected
//               pulse events; a monitor pops and compares on every pulse.
//               Honors BUTTON_AUTOREPEAT_EN for repeat expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

   localparam int NB  = 3;
   localparam int DC  = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
   localparam int LAT = 2 + DC;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] button_i;
   logic [NB-1:0] pressed_o;
   logic [NB-1:0] press_o;
   logic [NB-1:0] release_o;

   typedef struct {
      int            cyc;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] prs;
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  n_cmp  = 0;
   int  n_bad  = 0;
   bit  done   = 1'b0;

   button_debounce #(
      .NUM_BUTTONS    (NB),
      .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .button_i (button_i),
      .pressed_o(pressed_o),
      .press_o  (press_o),
      .release_o(release_o)
   );

   always #5 clk = ~clk;

   // Edge counter: at the falling edge following rising edge N, cyc == N
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse on press_o/release_o consumes one expected event
   always @(negedge clk) begin
      ev_t e;
      if (!done && (press_o != '0 || release_o != '0)) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b pressed=%b, expected no pulse",
                     cyc, press_o, release_o, pressed_o);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.press != press_o || e.rel != release_o || e.prs != pressed_o) begin
               n_bad++;
               $display("FAIL pulse_event got cyc=%0d press=%b release=%b pressed=%b, expected cyc=%0d press=%b release=%b pressed=%b",
                        cyc, press_o, release_o, pressed_o, e.cyc, e.press, e.rel, e.prs);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                       input logic [NB-1:0] s);
      ev_t e;
      e.cyc   = c;
      e.press = p;
      e.rel   = r;
      e.prs   = s;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%b expected=%b (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      int p;
      reset    = 1'b1;
      button_i = '1;
      tick(3);
      check("reset_pressed", pressed_o, 3'b000);
      check("reset_press",   press_o,   3'b000);
      check("reset_release", release_o, 3'b000);
      reset = 1'b0;
      tick(3);

      // Clean press on channel 0, released two cycles after the press pulse
      button_i[0] = 1'b0;
      push(cyc + LAT, 3'b001, 3'b000, 3'b001);
      tick(LAT + 2);
      check("clean_pressed_level", pressed_o, 3'b001);
      button_i[0] = 1'b1;
      push(cyc + LAT, 3'b000, 3'b001, 3'b000);
      tick(LAT + 2);
      check("release_level", pressed_o, 3'b000);

      // Bounce on channel 1: low 3, high 1, then low held
      button_i[1] = 1'b0;
      tick(3);
      button_i[1] = 1'b1;
      tick(1);
      button_i[1] = 1'b0;
      push(cyc + LAT, 3'b010, 3'b000, 3'b010);
      tick(LAT + 2);
      button_i[1] = 1'b1;
      push(cyc + LAT, 3'b000, 3'b010, 3'b000);
      tick(LAT + 2);

      // Single-cycle glitch on channel 2 must be ignored
      button_i[2] = 1'b0;
      tick(1);
      button_i[2] = 1'b1;
      tick(LAT + 2);
      check("glitch_level", pressed_o, 3'b000);

      // Reset at count 3 on channel 2 with the button held
      button_i[2] = 1'b0;
      tick(5);
      reset = 1'b1;
      tick(1);
      check("reset_midcount_pressed", pressed_o, 3'b000);
      reset = 1'b0;
      push(cyc + LAT, 3'b100, 3'b000, 3'b100);
      tick(LAT + 2);
      button_i[2] = 1'b1;
      push(cyc + LAT, 3'b000, 3'b100, 3'b000);
      tick(LAT + 2);

      // Long hold on channel 0: 30 cycles after the press pulse
      button_i[0] = 1'b0;
      p = cyc + LAT;
      push(p, 3'b001, 3'b000, 3'b001);
`ifdef BUTTON_AUTOREPEAT_EN
      for (int r = RD; r < 30 + LAT; r += RP) push(p + r, 3'b001, 3'b000, 3'b001);
`endif
      tick(LAT + 30);
      check("hold_level", pressed_o, 3'b001);
      button_i[0] = 1'b1;
      push(cyc + LAT, 3'b000, 3'b001, 3'b000);
      tick(LAT + 2);

      // All three channels pressed and released on the same cycle
      button_i = 3'b000;
      push(cyc + LAT, 3'b111, 3'b000, 3'b111);
      tick(LAT + 2);
      check("simul_level", pressed_o, 3'b111);
      button_i = 3'b111;
      push(cyc + LAT, 3'b000, 3'b111, 3'b000);
      tick(LAT + 4);

      done = 1'b1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_pulses got=%0d outstanding expected=0, next expected cyc=%0d",
                  exp_q.size(), exp_q[0].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
